// File: rtl/player_pkg.sv
// player_pkg: FSM states, direction codes and default field geometry shared by
// the player, hazard and collision blocks.
package player_pkg;
  localparam logic [1:0] ST_ALIVE = 2'd0;
  localparam logic [1:0] ST_DEAD  = 2'd1;
  localparam logic [1:0] ST_OVER  = 2'd2;
  localparam logic [1:0] DIR_UP = 2'd0;
  localparam logic [1:0] DIR_DN = 2'd1;
  localparam logic [1:0] DIR_LT = 2'd2;
  localparam logic [1:0] DIR_RT = 2'd3;
  localparam int TILE_SIZE = 32;
  localparam int GRID_COLS = 20;
  localparam int GRID_ROWS = 15;
  localparam int START_COL = 9;
  localparam int START_ROW = 14;
endpackage

// File: rtl/player_sprite_rom.sv
// player_sprite_rom: 32x32 one-bit player bitmap; bit c of row word r is pixel (r, c).
module player_sprite_rom (
  input  logic [4:0] i_Row,
  input  logic [4:0] i_Col,
  output logic       o_Bit
);
  localparam logic [31:0] BITMAP [32] = '{
    32'h00000000, 32'h00000000, 32'h00F00F00, 32'h01F81F80,
    32'h03FC3FC0, 32'h03CC33C0, 32'h03FC3FC0, 32'h01F81F80,
    32'h00FFFF00, 32'h07FFFFE0, 32'h0FFFFFF0, 32'h1FFFFFF8,
    32'h1FE007F8, 32'h3FC003FC, 32'h3F8001FC, 32'h3F8001FC,
    32'h3FC003FC, 32'h1FE007F8, 32'h1FFFFFF8, 32'h0FFFFFF0,
    32'h07FFFFE0, 32'h03FFFFC0, 32'h07E007E0, 32'h0FC003F0,
    32'h1F8001F8, 32'h3F0000FC, 32'h7E00007E, 32'hFC00003F,
    32'hF800001F, 32'h00000001, 32'h80000000, 32'h0000000F
  };
  assign o_Bit = BITMAP[i_Row][i_Col];
endmodule

// File: rtl/player_ctrl.sv
// player_ctrl: grid-stepped player with hold-to-repeat moves, lives/score,
// timed death with blink, and a registered sprite draw strobe.
module player_ctrl import player_pkg::*; #(
  parameter int c_TILE_SIZE    = TILE_SIZE,
  parameter int c_GRID_COLS    = GRID_COLS,
  parameter int c_GRID_ROWS    = GRID_ROWS,
  parameter int c_START_COL    = START_COL,
  parameter int c_START_ROW    = START_ROW,
  parameter int c_REPEAT_DELAY = 12750000,
  parameter int c_REPEAT_RATE  = 2550000,
  parameter int c_DEAD_TIME    = 25000000,
  parameter int c_BLINK_PERIOD = 3125000,
  parameter int c_LIVES        = 3
) (
  input  logic                           i_Clk,
  input  logic                           i_Rst_L,
  input  logic [9:0]                     i_Col_Count_Div,
  input  logic [9:0]                     i_Row_Count_Div,
  input  logic                           i_Up,
  input  logic                           i_Dn,
  input  logic                           i_Lt,
  input  logic                           i_Rt,
  input  logic                           i_Hit,
  input  logic                           i_Goal,
  input  logic                           i_Restart,
  output logic                           o_Draw_Player,
  output logic [$clog2(c_GRID_COLS)-1:0] o_Tile_Col,
  output logic [$clog2(c_GRID_ROWS)-1:0] o_Tile_Row,
  output logic [9:0]                     o_Player_X,
  output logic [9:0]                     o_Player_Y,
  output logic                           o_Hop,
  output logic [2:0]                     o_Lives,
  output logic [7:0]                     o_Score,
  output logic                           o_Dead,
  output logic                           o_Game_Over
);
  localparam int CW = $clog2(c_GRID_COLS);
  localparam int RW = $clog2(c_GRID_ROWS);
  localparam int TW = $clog2(c_TILE_SIZE);
  localparam int HW = $clog2(((c_REPEAT_DELAY > c_REPEAT_RATE) ? c_REPEAT_DELAY : c_REPEAT_RATE) + 1);
  localparam int DW = $clog2(c_DEAD_TIME + 1);
  localparam int BW = $clog2(c_BLINK_PERIOD + 1);
  logic [1:0] state_q, state_d, pdir_q, pdir_d, dir;
  logic [CW-1:0] col_q, col_d;
  logic [RW-1:0] row_q, row_d;
  logic [2:0] lives_q, lives_d;
  logic [7:0] score_q, score_d;
  logic [HW-1:0] hold_q, hold_d;
  logic [DW-1:0] dead_cnt_q, dead_cnt_d;
  logic [BW-1:0] blink_cnt_q, blink_cnt_d;
  logic hop_q, hop_d, pv_q, pv_d, rep_q, rep_d, blink_q, blink_d, draw_q, draw_d;
  logic valid, alive, edge_mv, rep_mv, can_move, accept, keep, in_dead, in_x, in_y, sprite_bit;
  logic [9:0] dx, dy;
  assign valid = $onehot({i_Up, i_Dn, i_Lt, i_Rt});
  assign dir = i_Up ? DIR_UP : i_Dn ? DIR_DN : i_Lt ? DIR_LT : DIR_RT;
  assign alive = state_q == ST_ALIVE;
  assign edge_mv = valid && (!pv_q || dir != pdir_q);
  assign rep_mv = valid && !edge_mv && hold_q == (rep_q ? HW'(c_REPEAT_RATE) : HW'(c_REPEAT_DELAY));
  assign can_move = dir == DIR_UP ? row_q != '0 :
                    dir == DIR_DN ? row_q != RW'(c_GRID_ROWS - 1) :
                    dir == DIR_LT ? col_q != '0 : col_q != CW'(c_GRID_COLS - 1);
  assign accept = alive && (edge_mv || rep_mv) && can_move && !i_Restart && !i_Hit && !i_Goal;
  always_comb begin
    state_d = state_q;
    col_d = col_q;
    row_d = row_q;
    lives_d = lives_q;
    score_d = score_q;
    hop_d = 1'b0;
    if (i_Restart) begin
      state_d = ST_ALIVE;
      lives_d = 3'(c_LIVES);
      score_d = '0;
      col_d = CW'(c_START_COL);
      row_d = RW'(c_START_ROW);
    end else if (alive && i_Hit) begin
      state_d = ST_DEAD;
      lives_d = lives_q - 3'd1;
    end else if (alive && i_Goal) begin
      score_d = (&score_q) ? score_q : score_q + 8'd1;
      col_d = CW'(c_START_COL);
      row_d = RW'(c_START_ROW);
    end else if (accept) begin
      col_d = dir == DIR_LT ? col_q - CW'(1) : dir == DIR_RT ? col_q + CW'(1) : col_q;
      row_d = dir == DIR_UP ? row_q - RW'(1) : dir == DIR_DN ? row_q + RW'(1) : row_q;
      hop_d = 1'b1;
    end else if (state_q == ST_DEAD && dead_cnt_q == DW'(c_DEAD_TIME - 1)) begin
      state_d = lives_q == '0 ? ST_OVER : ST_ALIVE;
      col_d = lives_q == '0 ? col_q : CW'(c_START_COL);
      row_d = lives_q == '0 ? row_q : RW'(c_START_ROW);
    end
  end
  // Press tracking survives only while ALIVE persists, so a button held
  // through a respawn counts as a fresh press.
  assign keep = alive && state_d == ST_ALIVE;
  assign in_dead = state_q == ST_DEAD && state_d == ST_DEAD;
  always_comb begin
    pv_d = keep && valid;
    pdir_d = dir;
    hold_d = !pv_d ? '0 : (edge_mv || rep_mv) ? HW'(1) : hold_q + 1'b1;
    rep_d = pv_d && !edge_mv && (rep_mv || rep_q);
    dead_cnt_d = in_dead ? dead_cnt_q + 1'b1 : '0;
    blink_cnt_d = (in_dead && blink_cnt_q != BW'(c_BLINK_PERIOD - 1)) ? blink_cnt_q + 1'b1 : '0;
    blink_d = !in_dead || (blink_q ^ (blink_cnt_q == BW'(c_BLINK_PERIOD - 1)));
  end
  assign dx = i_Col_Count_Div - o_Player_X;
  assign dy = i_Row_Count_Div - o_Player_Y;
  assign in_x = i_Col_Count_Div >= o_Player_X && dx < 10'(c_TILE_SIZE);
  assign in_y = i_Row_Count_Div >= o_Player_Y && dy < 10'(c_TILE_SIZE);
  assign draw_d = in_x && in_y && sprite_bit && (alive || (state_q == ST_DEAD && blink_q));
  player_sprite_rom u_sprite (
    .i_Row (5'(dy[TW-1:0])),
    .i_Col (5'(dx[TW-1:0])),
    .o_Bit (sprite_bit)
  );
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      state_q <= ST_ALIVE;
      col_q <= CW'(c_START_COL);
      row_q <= RW'(c_START_ROW);
      lives_q <= 3'(c_LIVES);
      score_q <= '0;
      hop_q <= 1'b0;
      pv_q <= 1'b0;
      pdir_q <= DIR_UP;
      hold_q <= '0;
      rep_q <= 1'b0;
      dead_cnt_q <= '0;
      blink_cnt_q <= '0;
      blink_q <= 1'b1;
      draw_q <= 1'b0;
    end else begin
      state_q <= state_d;
      col_q <= col_d;
      row_q <= row_d;
      lives_q <= lives_d;
      score_q <= score_d;
      hop_q <= hop_d;
      pv_q <= pv_d;
      pdir_q <= pdir_d;
      hold_q <= hold_d;
      rep_q <= rep_d;
      dead_cnt_q <= dead_cnt_d;
      blink_cnt_q <= blink_cnt_d;
      blink_q <= blink_d;
      draw_q <= draw_d;
    end
  end
  assign o_Tile_Col = col_q;
  assign o_Tile_Row = row_q;
  assign o_Player_X = 10'(col_q * c_TILE_SIZE);
  assign o_Player_Y = 10'(row_q * c_TILE_SIZE);
  assign o_Hop = hop_q;
  assign o_Lives = lives_q;
  assign o_Score = score_q;
  assign o_Dead = state_q == ST_DEAD;
  assign o_Game_Over = state_q == ST_OVER;
  assign o_Draw_Player = draw_q;
endmodule

// File: tb/tb_player_ctrl.sv
// tb_player_ctrl: directed plus random stimulus against a cycle-level game model;
// expectations are queued per cycle and compared by an independent monitor.
module tb_player_ctrl;
  localparam int DELAY = 10, RATE = 4, DEAD_T = 20, BLINK = 5;
  localparam logic [3:0] B_UP = 4'b1000, B_DN = 4'b0100, B_LT = 4'b0010, B_RT = 4'b0001, B_NO = 4'b0000;
  localparam logic [31:0] IMG [32] = '{
    32'h00000000, 32'h00000000, 32'h00F00F00, 32'h01F81F80,
    32'h03FC3FC0, 32'h03CC33C0, 32'h03FC3FC0, 32'h01F81F80,
    32'h00FFFF00, 32'h07FFFFE0, 32'h0FFFFFF0, 32'h1FFFFFF8,
    32'h1FE007F8, 32'h3FC003FC, 32'h3F8001FC, 32'h3F8001FC,
    32'h3FC003FC, 32'h1FE007F8, 32'h1FFFFFF8, 32'h0FFFFFF0,
    32'h07FFFFE0, 32'h03FFFFC0, 32'h07E007E0, 32'h0FC003F0,
    32'h1F8001F8, 32'h3F0000FC, 32'h7E00007E, 32'hFC00003F,
    32'hF800001F, 32'h00000001, 32'h80000000, 32'h0000000F
  };
  logic i_Clk = 1'b0, i_Rst_L = 1'b1;
  logic [9:0] i_Col_Count_Div = '0, i_Row_Count_Div = '0;
  logic i_Up = 1'b0, i_Dn = 1'b0, i_Lt = 1'b0, i_Rt = 1'b0, i_Hit = 1'b0, i_Goal = 1'b0, i_Restart = 1'b0;
  logic o_Draw_Player, o_Hop, o_Dead, o_Game_Over;
  logic [4:0] o_Tile_Col;
  logic [3:0] o_Tile_Row;
  logic [9:0] o_Player_X, o_Player_Y;
  logic [2:0] o_Lives;
  logic [7:0] o_Score;

  player_ctrl #(.c_REPEAT_DELAY(DELAY), .c_REPEAT_RATE(RATE), .c_DEAD_TIME(DEAD_T), .c_BLINK_PERIOD(BLINK)) dut (
    .i_Clk(i_Clk), .i_Rst_L(i_Rst_L), .i_Col_Count_Div(i_Col_Count_Div), .i_Row_Count_Div(i_Row_Count_Div),
    .i_Up(i_Up), .i_Dn(i_Dn), .i_Lt(i_Lt), .i_Rt(i_Rt), .i_Hit(i_Hit), .i_Goal(i_Goal), .i_Restart(i_Restart),
    .o_Draw_Player(o_Draw_Player), .o_Tile_Col(o_Tile_Col), .o_Tile_Row(o_Tile_Row),
    .o_Player_X(o_Player_X), .o_Player_Y(o_Player_Y), .o_Hop(o_Hop), .o_Lives(o_Lives),
    .o_Score(o_Score), .o_Dead(o_Dead), .o_Game_Over(o_Game_Over));

  always #5 i_Clk = ~i_Clk;

  typedef struct packed {
    logic [4:0] col; logic [3:0] row; logic [9:0] x; logic [9:0] y; logic hop;
    logic [2:0] lives; logic [7:0] score; logic dead; logic over; logic draw;
  } exp_t;
  exp_t q[$];
  int errors = 0, checks = 0, hops = 0, draws = 0;
  // model: state 0 alive / 1 dead / 2 game over
  int m_st, m_col, m_row, m_lives, m_score, m_dir, m_t, m_dt;
  bit scan_en = 1'b0;
  int scan_c, scan_r;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d @%0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_st = 0; m_col = 9; m_row = 14; m_lives = 3; m_score = 0; m_dir = -1; m_t = 0; m_dt = 0;
  endtask

  task automatic reset_chk(input string tag);
    chk({tag, "_col"}, int'(o_Tile_Col), 9);
    chk({tag, "_row"}, int'(o_Tile_Row), 14);
    chk({tag, "_x"}, int'(o_Player_X), 288);
    chk({tag, "_y"}, int'(o_Player_Y), 448);
    chk({tag, "_lives"}, int'(o_Lives), 3);
    chk({tag, "_score"}, int'(o_Score), 0);
    chk({tag, "_flags"}, int'({o_Hop, o_Dead, o_Game_Over, o_Draw_Player}), 0);
  endtask

  task automatic tick(input logic [3:0] b, input bit hit = 1'b0, input bit goal = 1'b0, input bit rs = 1'b0);
    int pc, pr, dxm, dym, nd, nc, nr, old;
    bit v, fire, ed, hop;
    exp_t e;
    @(negedge i_Clk);
    {i_Up, i_Dn, i_Lt, i_Rt} = b;
    i_Hit = hit; i_Goal = goal; i_Restart = rs;
    if (scan_en) begin
      pc = scan_c; pr = scan_r;
    end else begin
      pc = m_col * 32 + int'($urandom_range(44)) - 6;
      pr = m_row * 32 + int'($urandom_range(44)) - 6;
      if (pc < 0) pc = 0;
      if (pr < 0) pr = 0;
    end
    i_Col_Count_Div = 10'(pc);
    i_Row_Count_Div = 10'(pr);
    dxm = pc - m_col * 32;
    dym = pr - m_row * 32;
    ed = 1'b0;
    if (dxm >= 0 && dxm < 32 && dym >= 0 && dym < 32) ed = ((IMG[dym] >> dxm) & 32'd1) != 0;
    ed = ed && (m_st == 0 || (m_st == 1 && (m_dt / BLINK) % 2 == 0));
    v = $countones(b) == 1;
    nd = b[3] ? 0 : b[2] ? 1 : b[1] ? 2 : 3;
    fire = 1'b0;
    if (v) begin
      if (m_dir != nd) begin m_dir = nd; m_t = 0; end
      else m_t++;
      fire = m_t == 0 || m_t == DELAY || (m_t > DELAY && (m_t - DELAY) % RATE == 0);
    end else m_dir = -1;
    old = m_st;
    hop = 1'b0;
    if (rs) begin
      m_st = 0; m_lives = 3; m_score = 0; m_col = 9; m_row = 14;
    end else if (m_st == 0 && hit) begin
      m_st = 1; m_lives--; m_dt = 0;
    end else if (m_st == 0 && goal) begin
      if (m_score < 255) m_score++;
      m_col = 9; m_row = 14;
    end else if (m_st == 0 && fire) begin
      nc = m_col + int'(m_dir == 3) - int'(m_dir == 2);
      nr = m_row + int'(m_dir == 1) - int'(m_dir == 0);
      if (nc >= 0 && nc < 20 && nr >= 0 && nr < 15) begin m_col = nc; m_row = nr; hop = 1'b1; end
    end else if (m_st == 1) begin
      if (m_dt == DEAD_T - 1) begin
        if (m_lives == 0) m_st = 2;
        else begin m_st = 0; m_col = 9; m_row = 14; end
      end else m_dt++;
    end
    if (old != 0 || m_st != 0) m_dir = -1;
    e.col = 5'(m_col); e.row = 4'(m_row); e.x = 10'(m_col * 32); e.y = 10'(m_row * 32);
    e.hop = hop; e.lives = 3'(m_lives); e.score = 8'(m_score);
    e.dead = m_st == 1; e.over = m_st == 2; e.draw = ed;
    q.push_back(e);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(B_NO);
  endtask

  task automatic settle();
    @(posedge i_Clk);
    #2;
  endtask

  initial begin
    exp_t g, e;
    forever begin
      @(posedge i_Clk);
      #1;
      if (i_Rst_L && q.size() > 0) begin
        e = q.pop_front();
        g = {o_Tile_Col, o_Tile_Row, o_Player_X, o_Player_Y, o_Hop, o_Lives, o_Score, o_Dead, o_Game_Over, o_Draw_Player};
        hops += int'(o_Hop);
        draws += int'(o_Draw_Player);
        checks++;
        if (g !== e) begin
          errors++;
          $display("FAIL outputs @%0t: got col=%0d row=%0d x=%0d y=%0d hop=%0d lives=%0d score=%0d dead=%0d over=%0d draw=%0d; expected col=%0d row=%0d x=%0d y=%0d hop=%0d lives=%0d score=%0d dead=%0d over=%0d draw=%0d",
            $time, g.col, g.row, g.x, g.y, g.hop, g.lives, g.score, g.dead, g.over, g.draw,
            e.col, e.row, e.x, e.y, e.hop, e.lives, e.score, e.dead, e.over, e.draw);
        end
      end
    end
  end

  initial begin
    int h0, d0, ones, k, len;
    logic [3:0] pat;
    model_reset();
    #2 i_Rst_L = 1'b0;
    #1 reset_chk("reset");
    @(posedge i_Clk);
    #2 i_Rst_L = 1'b1;
    // single up pulse
    h0 = hops;
    tick(B_UP); idle(2); settle();
    chk("up_row", int'(o_Tile_Row), 13);
    chk("up_y", int'(o_Player_Y), 416);
    chk("up_hops", hops - h0, 1);
    // hold right for 20 cycles
    h0 = hops;
    for (int i = 0; i < 20; i++) tick(B_RT);
    idle(2); settle();
    chk("hold_col", int'(o_Tile_Col), 13);
    chk("hold_hops", hops - h0, 4);
    // two buttons together is idle
    h0 = hops;
    for (int i = 0; i < 5; i++) tick(B_UP | B_LT);
    idle(1); settle();
    chk("dual_col", int'(o_Tile_Col), 13);
    chk("dual_hops", hops - h0, 0);
    // bottom edge
    tick(B_DN); idle(2); settle();
    chk("dn_row", int'(o_Tile_Row), 14);
    h0 = hops;
    for (int i = 0; i < 3; i++) tick(B_DN);
    idle(1); settle();
    chk("edge_row", int'(o_Tile_Row), 14);
    chk("edge_hops", hops - h0, 0);
    // three hits to game over
    tick(B_NO, 1'b1); settle();
    chk("hit_dead", int'(o_Dead), 1);
    chk("hit_lives", int'(o_Lives), 2);
    idle(25); settle();
    chk("respawn_col", int'(o_Tile_Col), 9);
    chk("respawn_dead", int'(o_Dead), 0);
    tick(B_NO, 1'b1); idle(25);
    tick(B_NO, 1'b1); idle(25); settle();
    chk("over", int'(o_Game_Over), 1);
    chk("over_lives", int'(o_Lives), 0);
    d0 = draws;
    for (int i = 0; i < 30; i++) tick(4'($urandom_range(15)));
    settle();
    chk("over_no_draw", draws - d0, 0);
    tick(B_NO, 1'b0, 1'b0, 1'b1); settle();
    chk("restart_lives", int'(o_Lives), 3);
    chk("restart_score", int'(o_Score), 0);
    chk("restart_over", int'(o_Game_Over), 0);
    // hit beats goal, then goal alone
    tick(B_NO, 1'b1, 1'b1); settle();
    chk("hitgoal_dead", int'(o_Dead), 1);
    chk("hitgoal_score", int'(o_Score), 0);
    idle(25);
    h0 = hops;
    tick(B_UP); idle(1); tick(B_NO, 1'b0, 1'b1); settle();
    chk("goal_score", int'(o_Score), 1);
    chk("goal_row", int'(o_Tile_Row), 14);
    chk("goal_hops", hops - h0, 1);
    // pixel scan around the spawn tile
    ones = 0;
    for (int r = 0; r < 32; r++) ones += $countones(IMG[r]);
    d0 = draws;
    scan_en = 1'b1;
    for (int r = 444; r < 484; r++)
      for (int c = 284; c < 324; c++) begin
        scan_r = r; scan_c = c; tick(B_NO);
      end
    scan_en = 1'b0;
    settle();
    chk("scan_draws", draws - d0, ones);
    // score saturation
    for (int i = 0; i < 260; i++) tick(B_NO, 1'b0, 1'b1);
    settle();
    chk("score_sat", int'(o_Score), 255);
    // random traffic
    for (int n = 0; n < 150; n++) begin
      k = int'($urandom_range(7));
      pat = k == 0 ? B_NO : k < 5 ? 4'(1 << (k - 1)) : k == 5 ? 4'b1100 : k == 6 ? 4'b0101 : 4'b1111;
      len = int'($urandom_range(1, 25));
      for (int i = 0; i < len; i++)
        tick(pat, $urandom_range(149) == 0, $urandom_range(79) == 0,
             $urandom_range(299) == 0 || (m_st == 2 && $urandom_range(19) == 0));
    end
    // asynchronous reset in the middle of DEAD
    tick(B_NO, 1'b0, 1'b0, 1'b1); tick(B_NO, 1'b1); idle(8); settle();
    chk("middead", int'(o_Dead), 1);
    i_Rst_L = 1'b0;
    q.delete();
    #1 reset_chk("midrst");
    model_reset();
    @(posedge i_Clk);
    #2 i_Rst_L = 1'b1;
    tick(B_UP); idle(2); settle();
    chk("post_rst_row", int'(o_Tile_Row), 13);
    for (int i = 0; i < 10 && q.size() > 0; i++) settle();
    chk("queue_drained", q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
